klaw_dmem: RTL

Data-memory subsystem directly downstream of the core's data port. It serves loads and stores in one cycle from a local word-organised array, so the core never stalls. Stores falling in the MMIO window are posted into a small FIFO and drained to an external valid/ready port. Misaligned accesses are suppressed and flagged.

---
 rtl/riscv_pkg.sv | 20 ++
 rtl/klaw_store_fifo.sv | 57 +++++
 rtl/klaw_dmem.sv | 125 ++++++++++++
 3 files changed

// File: rtl/riscv_pkg.sv
// Shared types for the data-memory path: access sizes, the posted MMIO
// request record and the default MMIO window base.
package riscv_pkg;

    localparam int XLEN = 32;
    localparam logic [XLEN-1:0] MMIO_BASE_DEFAULT = 32'h1000_0000;

    typedef enum logic [1:0] {
        SIZE_B = 2'b00,
        SIZE_H = 2'b01,
        SIZE_W = 2'b10
    } access_size_e;

    typedef struct packed {
        logic [XLEN-1:0] adr;
        logic [XLEN-1:0] data;
        logic [3:0]      strb;
    } mmio_req_t;

endpackage

// File: rtl/klaw_store_fifo.sv
// Posted-store FIFO for MMIO writes. A push into a full FIFO is accepted only
// when a pop frees a slot in the same cycle; otherwise it is dropped and flagged.
module klaw_store_fifo
    import riscv_pkg::*;
#(
    parameter int DEPTH = 4,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic      clk,
    input  logic      reset_n,
    input  logic      push,
    input  mmio_req_t push_req,
    output logic      full,
    input  logic      pop,
    output mmio_req_t head,
    output logic      empty,
    output logic [AW:0] count,
    output logic      overflow_q
);

    mmio_req_t       mem [DEPTH];
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic            do_push;
    logic            do_pop;

    assign empty   = (count == '0);
    assign full    = (count == (AW+1)'(DEPTH));
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            overflow_q <= 1'b0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: ;
            endcase
            if (push && !do_push) overflow_q <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_req;
    end

    // Storage is not reset, so the head is forced to zero while empty.
    assign head = empty ? '0 : mem[rd_ptr];

endmodule

// File: rtl/klaw_dmem.sv
// Single-cycle data memory: local word array for low addresses, posted MMIO
// store FIFO for the window at and above MMIO_BASE, misaligned accesses dropped.
module klaw_dmem
    import riscv_pkg::*;
#(
    parameter int              MEM_WORDS  = 4096,
    parameter logic [XLEN-1:0] MMIO_BASE  = MMIO_BASE_DEFAULT,
    parameter int              FIFO_DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic                          adr_v_i,
    input  logic [XLEN-1:0]               adr_i,
    input  logic                          is_store_i,
    input  logic [XLEN-1:0]               store_data_i,
    input  logic [2:0]                    access_size_i,
    output logic [XLEN-1:0]               load_data_o,
    output logic                          misaligned_o,
    output logic                          mmio_valid_o,
    input  logic                          mmio_ready_i,
    output logic [XLEN-1:0]               mmio_adr_o,
    output logic [XLEN-1:0]               mmio_data_o,
    output logic [3:0]                    mmio_strb_o,
    output logic                          overflow_q_o,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count_q_o
);

    localparam int IW = $clog2(MEM_WORDS);

    logic [XLEN-1:0] mem [MEM_WORDS];

    logic [1:0]      off;
    logic [3:0]      strb;
    logic [XLEN-1:0] wdata;
    logic            bad_align;
    logic            acc_ok;
    logic            is_local;
    logic            local_we;
    logic            mmio_push;
    logic [IW-1:0]   word_idx;
    logic [XLEN-1:0] rshift;
    logic [XLEN-1:0] rlane;
    mmio_req_t       push_req;
    mmio_req_t       head;
    logic            fifo_empty;
    logic            fifo_full_unused;
    logic            unused_size_bit;

    assign off             = adr_i[1:0];
    assign word_idx        = adr_i[2 +: IW];
    assign is_local        = (adr_i < MMIO_BASE);
    assign unused_size_bit = access_size_i[2];

    // Strobes and lane-replicated store data; size 11 is reported as misaligned.
    always_comb begin
        strb      = 4'h0;
        wdata     = '0;
        bad_align = 1'b0;
        case (access_size_i[1:0])
            SIZE_B: begin
                strb  = 4'b0001 << off;
                wdata = {4{store_data_i[7:0]}};
            end
            SIZE_H: begin
                strb      = 4'b0011 << off;
                wdata     = {2{store_data_i[15:0]}};
                bad_align = off[0];
            end
            SIZE_W: begin
                strb      = 4'hF;
                wdata     = store_data_i;
                bad_align = (off != 2'b00);
            end
            default: bad_align = 1'b1;
        endcase
    end

    assign misaligned_o = adr_v_i && bad_align;
    assign acc_ok       = adr_v_i && !bad_align;
    assign local_we     = acc_ok && is_store_i && is_local;
    assign mmio_push    = acc_ok && is_store_i && !is_local;

    always_ff @(posedge clk) begin
        if (local_we) begin
            for (int b = 0; b < 4; b++) begin
                if (strb[b]) mem[word_idx][8*b +: 8] <= wdata[8*b +: 8];
            end
        end
    end

    assign rshift = mem[word_idx] >> {off, 3'b000};

    always_comb begin
        case (access_size_i[1:0])
            SIZE_B:  rlane = rshift & 32'h0000_00FF;
            SIZE_H:  rlane = rshift & 32'h0000_FFFF;
            default: rlane = rshift;
        endcase
    end

    assign load_data_o = (acc_ok && !is_store_i && is_local) ? rlane : '0;

    assign push_req.adr  = {adr_i[XLEN-1:2], 2'b00};
    assign push_req.data = wdata;
    assign push_req.strb = strb;

    klaw_store_fifo #(.DEPTH(FIFO_DEPTH)) u_store_fifo (
        .clk        (clk),
        .reset_n    (reset_n),
        .push       (mmio_push),
        .push_req   (push_req),
        .full       (fifo_full_unused),
        .pop        (mmio_ready_i),
        .head       (head),
        .empty      (fifo_empty),
        .count      (fifo_count_q_o),
        .overflow_q (overflow_q_o)
    );

    assign mmio_valid_o = !fifo_empty;
    assign mmio_adr_o   = head.adr;
    assign mmio_data_o  = head.data;
    assign mmio_strb_o  = head.strb;

endmodule
